// File: rtl/imu_pkg.sv
// Shared constants and types for the IMU sample filter: channel count, raw
// word width, read-port status address and the filter FSM encoding.
package imu_pkg;

    localparam int         NUM_CH      = 6;
    localparam int         RAW_W       = 16;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        UPDATE = 2'd3
    } state_e;

    typedef logic [2:0]       ch_idx_t;
    typedef logic [RAW_W-1:0] raw_t;

    function automatic logic [31:0] sext32(input raw_t v);
        return {{(32 - RAW_W){v[RAW_W-1]}}, v};
    endfunction

endpackage

// File: rtl/imu_change_detect.sv
// Change detection for the raw channel set: compares the live words against
// the last accepted snapshot and requires them to sit still before accepting.
module imu_change_detect
    import imu_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH*RAW_W-1:0]   raw_flat,
    input  logic [NUM_CH*RAW_W-1:0]   snap_flat,
    input  logic                      in_idle,
    input  logic                      in_settle,
    output logic                      changed,
    output logic                      accept,
    output logic                      revert
);

    localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    logic [NUM_CH*RAW_W-1:0] prev_q, prev_d;
    logic [STAB_W-1:0]       stab_cnt_q, stab_cnt_d;
    logic                    moving;

    always_comb begin
        // NOTE: every output of this block is assigned before any branch so no latch is inferred.
        changed    = (raw_flat != snap_flat);
        moving     = (raw_flat != prev_q);
        accept     = in_settle && !moving && changed && (stab_cnt_q == STAB_LAST);
        revert     = in_settle && !moving && !changed;
        prev_d     = raw_flat;
        stab_cnt_d = stab_cnt_q;

        // A moving input restarts the stability window; acceptance or revert ends it.
        if (in_idle || (in_settle && (moving || accept || revert))) begin
            stab_cnt_d = '0;
        end else if (in_settle) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= '0;
            stab_cnt_q <= '0;
        end else begin
            prev_q     <= prev_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

endmodule

// File: rtl/imu_sample_filter.sv
// Per-channel moving-average filter over accepted IMU raw sets, with a shared
// accumulate datapath stepping one channel per cycle and a registered read port.
module imu_sample_filter
    import imu_pkg::*;
#(
    parameter int LOG2_AVG      = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] raw_0,
    input  logic [31:0] raw_1,
    input  logic [31:0] raw_2,
    input  logic [31:0] raw_3,
    input  logic [31:0] raw_4,
    input  logic [31:0] raw_5,
    input  logic        rd_en,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        data_ready,
    output logic [15:0] sample_cnt
);

    localparam int N      = 1 << LOG2_AVG;
    localparam int ACC_W  = RAW_W + LOG2_AVG;
    localparam int WP_W   = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int FILL_W = LOG2_AVG + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

    typedef logic signed [ACC_W-1:0] acc_t;

    function automatic raw_t avg_of(input acc_t a);
        acc_t s;
        s = a >>> LOG2_AVG;
        return s[RAW_W-1:0];
    endfunction

    raw_t raw_lo [NUM_CH];
    logic [NUM_CH*RAW_W-1:0] raw_flat, snap_flat;
    logic unused_raw_hi;

    state_e            state_q, state_d;
    ch_idx_t           ch_q, ch_d;
    logic [WP_W-1:0]   wp_q, wp_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    raw_t              snap_q [NUM_CH];
    raw_t              snap_d [NUM_CH];
    raw_t              hist_q [NUM_CH][N];
    raw_t              hist_d [NUM_CH][N];
    acc_t              acc_q  [NUM_CH];
    acc_t              acc_d  [NUM_CH];
    raw_t              filt_q [NUM_CH];
    raw_t              filt_d [NUM_CH];
    logic [31:0]       rd_data_q, rd_data_d;
    logic              data_ready_q, data_ready_d;
    logic [15:0]       sample_cnt_q, sample_cnt_d;

    logic changed, accept, revert, update_full;
    acc_t hist_ext, snap_ext, acc_sum;

    assign raw_lo[0] = raw_0[RAW_W-1:0];
    assign raw_lo[1] = raw_1[RAW_W-1:0];
    assign raw_lo[2] = raw_2[RAW_W-1:0];
    assign raw_lo[3] = raw_3[RAW_W-1:0];
    assign raw_lo[4] = raw_4[RAW_W-1:0];
    assign raw_lo[5] = raw_5[RAW_W-1:0];
    assign unused_raw_hi = ^{raw_0[31:RAW_W], raw_1[31:RAW_W], raw_2[31:RAW_W],
                             raw_3[31:RAW_W], raw_4[31:RAW_W], raw_5[31:RAW_W]};

    always_comb begin
        raw_flat  = '0;
        snap_flat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            raw_flat[k*RAW_W +: RAW_W]  = raw_lo[k];
            snap_flat[k*RAW_W +: RAW_W] = snap_q[k];
        end
    end

    imu_change_detect #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_change_detect (
        .clk       (clk),
        .reset     (reset),
        .raw_flat  (raw_flat),
        .snap_flat (snap_flat),
        .in_idle   (state_q == IDLE),
        .in_settle (state_q == SETTLE),
        .changed   (changed),
        .accept    (accept),
        .revert    (revert)
    );

    // Single shared adder: retire the oldest history entry and add the new sample.
    always_comb begin
        hist_ext = ACC_W'($signed(hist_q[ch_q][wp_q]));
        snap_ext = ACC_W'($signed(snap_q[ch_q]));
        acc_sum  = acc_q[ch_q] - hist_ext + snap_ext;
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        wp_d         = wp_q;
        fill_d       = fill_q;
        snap_d       = snap_q;
        hist_d       = hist_q;
        acc_d        = acc_q;
        filt_d       = filt_q;
        sample_cnt_d = sample_cnt_q;
        update_full  = 1'b0;

        case (state_q)
            IDLE: begin
                if (changed) state_d = SETTLE;
            end
            SETTLE: begin
                if (revert) begin
                    state_d = IDLE;
                end else if (accept) begin
                    snap_d       = raw_lo;
                    sample_cnt_d = sample_cnt_q + 16'd1;
                    ch_d         = '0;
                    state_d      = ACCUM;
                end
            end
            ACCUM: begin
                acc_d[ch_q]        = acc_sum;
                hist_d[ch_q][wp_q] = snap_q[ch_q];
                if (ch_q == ch_idx_t'(NUM_CH - 1)) begin
                    wp_d    = (N == 1) ? '0 : wp_q + 1'b1;
                    fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
                    state_d = UPDATE;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            UPDATE: begin
                if (fill_q == FILL_FULL) begin
                    for (int k = 0; k < NUM_CH; k++) filt_d[k] = avg_of(acc_q[k]);
                    update_full = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_data_d    = rd_data_q;
        data_ready_d = data_ready_q;
        if (rd_en) begin
            if (rd_addr < 3'(NUM_CH)) begin
                rd_data_d = sext32(filt_q[rd_addr]);
            end else if (rd_addr == ADDR_STATUS) begin
                rd_data_d    = {sample_cnt_q, 15'b0, data_ready_q};
                data_ready_d = 1'b0;
            end else begin
                rd_data_d = '0;
            end
        end
        // A fresh filtered set overrides a status read landing in the same cycle.
        if (update_full) data_ready_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            wp_q         <= '0;
            fill_q       <= '0;
            snap_q       <= '{default: '0};
            // NOTE: history must be cleared with the accumulators, or the first N passes subtract stale samples.
            hist_q       <= '{default: '{default: '0}};
            acc_q        <= '{default: '0};
            filt_q       <= '{default: '0};
            rd_data_q    <= '0;
            data_ready_q <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            wp_q         <= wp_d;
            fill_q       <= fill_d;
            snap_q       <= snap_d;
            hist_q       <= hist_d;
            acc_q        <= acc_d;
            filt_q       <= filt_d;
            rd_data_q    <= rd_data_d;
            data_ready_q <= data_ready_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign data_ready = data_ready_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_imu_sample_filter.sv
// Directed bench for imu_sample_filter: warm-up, signed averaging, glitch
// rejection, status read/update collision and reset during accumulation.
module tb_imu_sample_filter;

    logic        clk;
    logic        reset;
    logic [31:0] raw_0, raw_1, raw_2, raw_3, raw_4, raw_5;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        data_ready;
    logic [15:0] sample_cnt;

    int n_cmp;
    int n_bad;

    imu_sample_filter #(
        .LOG2_AVG      (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_0      (raw_0),
        .raw_1      (raw_1),
        .raw_2      (raw_2),
        .raw_3      (raw_3),
        .raw_4      (raw_4),
        .raw_5      (raw_5),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .data_ready (data_ready),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns the registered read data one cycle later.
    task automatic do_read(input logic [2:0] a, output logic [31:0] v);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en   = 1'b0;
        v       = rd_data;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b1;
        raw_0 = 32'h1234_5678; raw_1 = 32'h0000_00FF; raw_2 = 32'hABCD_0001;
        raw_3 = 32'h0000_8000; raw_4 = 32'h0000_7FFF; raw_5 = 32'h0000_0042;
        wait_cycles(3);
        n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data: got %08h want 00000000", rd_data); end
        n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL reset_data_ready: got %0b want 0", data_ready); end
        n_cmp++; if (sample_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_sample_cnt: got %0d want 0", sample_cnt); end
        raw_0 = '0; raw_1 = '0; raw_2 = '0; raw_3 = '0; raw_4 = '0; raw_5 = '0;
        reset = 1'b0;
        wait_cycles(30);
        n_cmp++; if (sample_cnt !== 16'd0) begin n_bad++; $display("FAIL zero_raw_no_accept: got %0d want 0", sample_cnt); end
        do_read(3'd6, v);
        n_cmp++; if (v !== 32'h0000_0000) begin n_bad++; $display("FAIL reset_status_read: got %08h want 00000000", v); end
    endtask

    task automatic test_average;
        logic [31:0] v;
        raw_0 = 32'd4;  wait_cycles(20);
        raw_0 = 32'd8;  wait_cycles(20);
        raw_0 = 32'd12; wait_cycles(20);
        n_cmp++; if (sample_cnt !== 16'd3) begin n_bad++; $display("FAIL avg_cnt3: got %0d want 3", sample_cnt); end
        n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL avg_warmup_ready: got %0b want 0", data_ready); end
        raw_0 = 32'd16; wait_cycles(20);
        n_cmp++; if (data_ready !== 1'b1) begin n_bad++; $display("FAIL avg_ready: got %0b want 1", data_ready); end
        do_read(3'd7, v);
        n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL addr7_read: got %08h want 00000000", v); end
        do_read(3'd0, v);
        n_cmp++; if (v !== 32'h0000_000A) begin n_bad++; $display("FAIL avg_ch0: got %08h want 0000000A", v); end
        wait_cycles(3);
        n_cmp++; if (rd_data !== 32'h0000_000A) begin n_bad++; $display("FAIL rd_hold: got %08h want 0000000A", rd_data); end
        do_read(3'd6, v);
        n_cmp++; if (v !== 32'h0004_0001) begin n_bad++; $display("FAIL avg_status: got %08h want 00040001", v); end
        n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL avg_read_clear: got %0b want 0", data_ready); end
    endtask

    task automatic test_signed;
        logic [31:0] v;
        raw_0 = 32'hDEAD_0010;
        wait_cycles(20);
        n_cmp++; if (sample_cnt !== 16'd4) begin n_bad++; $display("FAIL upper_bits_ignored: got %0d want 4", sample_cnt); end
        raw_1 = 32'hDEAD_FFF8; wait_cycles(20);
        raw_1 = 32'hDEAD_FFE8; wait_cycles(20);
        raw_1 = 32'hDEAD_FFF8; wait_cycles(20);
        raw_1 = 32'hDEAD_FFE8; wait_cycles(20);
        n_cmp++; if (sample_cnt !== 16'd8) begin n_bad++; $display("FAIL signed_cnt: got %0d want 8", sample_cnt); end
        do_read(3'd1, v);
        n_cmp++; if (v !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL signed_ch1: got %08h want FFFFFFF0", v); end
        do_read(3'd0, v);
        n_cmp++; if (v !== 32'h0000_0010) begin n_bad++; $display("FAIL steady_ch0: got %08h want 00000010", v); end
        do_read(3'd6, v);
        n_cmp++; if (v !== 32'h0008_0001) begin n_bad++; $display("FAIL signed_status: got %08h want 00080001", v); end
    endtask

    task automatic test_glitch;
        logic [31:0] v;
        raw_2 = 32'd5; wait_cycles(2);
        raw_2 = 32'd0; wait_cycles(10);
        n_cmp++; if (sample_cnt !== 16'd8) begin n_bad++; $display("FAIL glitch_revert: got %0d want 8", sample_cnt); end
        for (int i = 0; i < 26; i++) begin
            raw_2 = (i % 2 == 0) ? 32'd5 : 32'd0;
            wait_cycles(2);
        end
        wait_cycles(10);
        n_cmp++; if (sample_cnt !== 16'd8) begin n_bad++; $display("FAIL glitch_toggle: got %0d want 8", sample_cnt); end
        raw_2 = 32'd5; wait_cycles(20);
        n_cmp++; if (sample_cnt !== 16'd9) begin n_bad++; $display("FAIL glitch_held_accept: got %0d want 9", sample_cnt); end
        do_read(3'd2, v);
        n_cmp++; if (v !== 32'h0000_0001) begin n_bad++; $display("FAIL glitch_ch2: got %08h want 00000001", v); end
        do_read(3'd1, v);
        n_cmp++; if (v !== 32'hFFFF_FFEC) begin n_bad++; $display("FAIL window_ch1: got %08h want FFFFFFEC", v); end
        do_read(3'd6, v);
        n_cmp++; if (v !== 32'h0009_0001) begin n_bad++; $display("FAIL glitch_status: got %08h want 00090001", v); end
    endtask

    task automatic test_update_race;
        logic [31:0] v;
        // Change seen at edge 1, accept at edge 5, ACCUM on edges 6..11, UPDATE at edge 12.
        raw_3 = 32'd7;
        wait_cycles(11);
        do_read(3'd6, v);
        n_cmp++; if (v !== 32'h000A_0000) begin n_bad++; $display("FAIL race_status_old: got %08h want 000A0000", v); end
        n_cmp++; if (data_ready !== 1'b1) begin n_bad++; $display("FAIL race_set_wins: got %0b want 1", data_ready); end
        do_read(3'd6, v);
        n_cmp++; if (v !== 32'h000A_0001) begin n_bad++; $display("FAIL race_status_new: got %08h want 000A0001", v); end
        n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL race_clear: got %0b want 0", data_ready); end
    endtask

    task automatic test_reset_mid_accum;
        logic [31:0] v;
        // After 8 edges from the change, the channel counter sits at 3.
        raw_4 = 32'h0000_0055;
        wait_cycles(8);
        reset = 1'b1;
        #1;
        n_cmp++; if (sample_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_reset_cnt: got %0d want 0", sample_cnt); end
        n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL mid_reset_rd_data: got %08h want 00000000", rd_data); end
        @(negedge clk);
        raw_4 = 32'd0;
        reset = 1'b0;
        wait_cycles(20);
        n_cmp++; if (sample_cnt !== 16'd1) begin n_bad++; $display("FAIL post_reset_set1: got %0d want 1", sample_cnt); end
        raw_4 = 32'd1; wait_cycles(20);
        raw_4 = 32'd2; wait_cycles(20);
        n_cmp++; if (sample_cnt !== 16'd3) begin n_bad++; $display("FAIL post_reset_cnt3: got %0d want 3", sample_cnt); end
        n_cmp++; if (data_ready !== 1'b0) begin n_bad++; $display("FAIL post_reset_warmup: got %0b want 0", data_ready); end
        raw_4 = 32'd3; wait_cycles(20);
        n_cmp++; if (data_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %0b want 1", data_ready); end
        do_read(3'd4, v);
        n_cmp++; if (v !== 32'h0000_0001) begin n_bad++; $display("FAIL post_reset_ch4: got %08h want 00000001", v); end
        do_read(3'd1, v);
        n_cmp++; if (v !== 32'hFFFF_FFE8) begin n_bad++; $display("FAIL post_reset_ch1: got %08h want FFFFFFE8", v); end
        do_read(3'd3, v);
        n_cmp++; if (v !== 32'h0000_0007) begin n_bad++; $display("FAIL post_reset_ch3: got %08h want 00000007", v); end
        do_read(3'd6, v);
        n_cmp++; if (v !== 32'h0004_0001) begin n_bad++; $display("FAIL post_reset_status: got %08h want 00040001", v); end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rd_en   = 1'b0;
        rd_addr = 3'd0;
        reset   = 1'b1;
        raw_0 = '0; raw_1 = '0; raw_2 = '0; raw_3 = '0; raw_4 = '0; raw_5 = '0;
        @(negedge clk);
        test_reset();
        test_average();
        test_signed();
        test_glitch();
        test_update_race();
        test_reset_mid_accum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
